// File: rtl/immu_pkg.sv
// immu_pkg: shared types and constants for the I-cache line-fill responder.
//   - FSM state encoding (IDLE, FILL, RESP, RECOVER)
//   - line geometry: 8 words of 32 bits, 32-byte lines
//   - tag/counter widths and a line-base helper
package immu_pkg;

  localparam int LINE_WORDS = 8;
  localparam int LINE_OFF_W = 5;
  localparam int WORD_OFF_W = 2;
  localparam int WORD_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int LINE_W     = LINE_WORDS * WORD_W;
  localparam int TAG_W      = ADDR_W - LINE_OFF_W;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    RESP    = 2'd2,
    RECOVER = 2'd3
  } immu_state_e;

  // Byte address of the first word of the line containing addr.
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/immu_line_fill_if.sv
// immu_line_fill_if: request/response bundle between the I-cache, the
// line-fill responder and the word-wide backing memory.
//   I-cache side : immu_read, immu_addr, inv_line (to responder)
//                  immu_done, immu_read_data     (from responder)
//   memory side  : mem_req, mem_addr             (from responder)
//                  mem_gnt, mem_rvalid, mem_rdata (to responder)
// slave  : view taken by the line-fill responder
// master : view taken by the surrounding environment (cache + memory)
interface immu_line_fill_if import immu_pkg::*; ();

  logic              immu_read;
  logic [ADDR_W-1:0] immu_addr;
  logic              immu_done;
  logic [LINE_W-1:0] immu_read_data;
  logic              inv_line;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [WORD_W-1:0] mem_rdata;

  modport slave (
    input  immu_read, immu_addr, inv_line, mem_gnt, mem_rvalid, mem_rdata,
    output immu_done, immu_read_data, mem_req, mem_addr
  );

  modport master (
    output immu_read, immu_addr, inv_line, mem_gnt, mem_rvalid, mem_rdata,
    input  immu_done, immu_read_data, mem_req, mem_addr
  );

endinterface

// File: rtl/immu_line_asm.sv
// immu_line_asm: assembles the eight returned memory words into one line.
//   sys_clk, rst : clock and synchronous active-high reset
//   clear        : start of a new fill, rewinds the receive counter
//   word_we      : a response word is valid this cycle
//   word_data    : response word
//   line_data    : assembled line, word i at [32*i+31:32*i]
//   last_word    : the eighth word of the line is being written now
module immu_line_asm
  import immu_pkg::*;
(
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              word_we,
  input  logic [WORD_W-1:0] word_data,
  output logic [LINE_W-1:0] line_data,
  output logic              last_word
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_WORDS - 1);

  logic [CNT_W-1:0]  recv_cnt_reg;
  logic [WORD_W-1:0] word_reg [LINE_WORDS];

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      recv_cnt_reg <= '0;
    end else if (clear) begin
      recv_cnt_reg <= '0;
    end else if (word_we) begin
      recv_cnt_reg <= recv_cnt_reg + CNT_W'(1);
    end
  end

  // Responses are in order, so the receive counter selects the word slot.
  genvar gi;
  generate
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_word
      always_ff @(posedge sys_clk) begin
        if (rst) begin
          word_reg[gi] <= '0;
        end else if (word_we && (recv_cnt_reg == CNT_W'(gi))) begin
          word_reg[gi] <= word_data;
        end
      end
      assign line_data[gi*WORD_W +: WORD_W] = word_reg[gi];
    end
  endgenerate

  assign last_word = word_we && (recv_cnt_reg == LAST_IDX);

endmodule

// File: rtl/immu_line_fill.sv
// immu_line_fill: memory-side responder for I-cache line-fill requests.
// Accepts a held read request, fetches the aligned 32-byte line as eight
// pipelined word reads (at most MAX_OUT in flight, MAX_OUT in 1..4), and
// returns the line with a one-cycle done pulse followed by one recovery
// cycle in which new requests are ignored.
//   sys_clk : clock, all logic on the rising edge
//   rst     : synchronous active-high reset
//   bus     : immu_line_fill_if.slave (I-cache request side + memory port)
// Optional build macro IMMU_LAST_LINE_EN: remembers the tag of the last
// completed line; a matching request is answered from the held line
// without touching memory. inv_line drops the remembered line.
module immu_line_fill
  import immu_pkg::*;
#(
  parameter int MAX_OUT = 2
)
(
  input  logic            sys_clk,
  input  logic            rst,
  immu_line_fill_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_OUT_C    = CNT_W'(MAX_OUT);
  localparam logic [CNT_W-1:0] LINE_WORDS_C = CNT_W'(LINE_WORDS);

  immu_state_e       state_reg, state_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [CNT_W-1:0]  issue_cnt_reg, issue_cnt_next;
  logic [CNT_W-1:0]  out_cnt_reg, out_cnt_next;

  logic              fill_start;
  logic              word_we;
  logic              last_word;
  logic              grant;
  logic              hit;
  logic [LINE_W-1:0] line_data;

`ifdef IMMU_LAST_LINE_EN
  logic [TAG_W-1:0] tag_reg;
  logic             tag_valid_reg;
  logic             unused_addr_bits;

  // An invalidate in the same cycle wins over a hit.
  assign hit = tag_valid_reg && !bus.inv_line &&
               (tag_reg == bus.immu_addr[ADDR_W-1:LINE_OFF_W]);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      tag_reg       <= '0;
      tag_valid_reg <= 1'b0;
    end else if (bus.inv_line) begin
      tag_valid_reg <= 1'b0;
    end else if ((state_reg == FILL) && last_word) begin
      tag_reg       <= base_reg[ADDR_W-1:LINE_OFF_W];
      tag_valid_reg <= 1'b1;
    end
  end

  assign unused_addr_bits = ^bus.immu_addr[LINE_OFF_W-1:0];
`else
  logic unused_addr_bits;

  assign hit = 1'b0;
  assign unused_addr_bits = ^{bus.inv_line, bus.immu_addr[LINE_OFF_W-1:0]};
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      issue_cnt_reg <= '0;
      out_cnt_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      base_reg      <= base_next;
      issue_cnt_reg <= issue_cnt_next;
      out_cnt_reg   <= out_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    base_next      = base_reg;
    issue_cnt_next = issue_cnt_reg;
    out_cnt_next   = out_cnt_reg;
    fill_start     = 1'b0;
    word_we        = 1'b0;
    grant          = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_addr   = '0;
    bus.immu_done  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        // Stray responses here are simply not written anywhere.
        if (bus.immu_read) begin
          base_next      = line_base(bus.immu_addr);
          issue_cnt_next = '0;
          out_cnt_next   = '0;
          if (hit) begin
            state_next = RESP;
          end else begin
            state_next = FILL;
            fill_start = 1'b1;
          end
        end
      end

      FILL: begin
        bus.mem_req  = (issue_cnt_reg < LINE_WORDS_C) && (out_cnt_reg < MAX_OUT_C);
        bus.mem_addr = base_reg + (ADDR_W'(issue_cnt_reg) << WORD_OFF_W);
        grant        = bus.mem_req && bus.mem_gnt;
        word_we      = bus.mem_rvalid;
        if (grant) begin
          issue_cnt_next = issue_cnt_reg + CNT_W'(1);
        end
        // Grant and response in the same cycle cancel out.
        unique case ({grant, bus.mem_rvalid})
          2'b10:   out_cnt_next = out_cnt_reg + CNT_W'(1);
          2'b01:   out_cnt_next = out_cnt_reg - CNT_W'(1);
          default: out_cnt_next = out_cnt_reg;
        endcase
        if (last_word) begin
          state_next = RESP;
        end
      end

      RESP: begin
        bus.immu_done = 1'b1;
        state_next    = RECOVER;
      end

      RECOVER: begin
        // Gives the initiator one cycle to lower its request.
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  immu_line_asm u_line_asm (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .clear     (fill_start),
    .word_we   (word_we),
    .word_data (bus.mem_rdata),
    .line_data (line_data),
    .last_word (last_word)
  );

  // The line register is only rewritten by a fill, so it stays stable
  // from the done pulse until the next fill begins.
  assign bus.immu_read_data = line_data;

  a_out_max: assert property (@(posedge sys_clk) disable iff (rst)
    out_cnt_reg <= MAX_OUT_C);

  a_out_no_underflow: assert property (@(posedge sys_clk) disable iff (rst)
    ((state_reg == FILL) && bus.mem_rvalid) |-> (out_cnt_reg != '0));

endmodule

// File: tb/tb_immu_line_fill.sv
`timescale 1ns/1ps
module tb_immu_line_fill;
  import immu_pkg::*;

  localparam int MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  immu_line_fill_if bus ();

  immu_line_fill #(.MAX_OUT(MAX_OUT)) dut (
    .sys_clk (clk),
    .rst     (rst),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } pend_t;

  pend_t        pend_q[$];
  logic [31:0]  exp_addr_q[$];
  logic [255:0] exp_line_q[$];

  logic [31:0] mem_seed   = 32'h0;
  int          lat        = 1;
  bit          gnt_toggle = 1'b0;
  int          tb_out     = 0;
  int          rv_cnt     = 0;
  int          req_seen   = 0;
  int          done_cnt   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  function automatic logic [255:0] line_of(input logic [31:0] seed);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = 32'hA000_0000 + seed + 32'(i);
    return l;
  endfunction

  task automatic push_addrs(input logic [31:0] addr);
    logic [31:0] b;
    b = {addr[31:5], 5'b0};
    for (int i = 0; i < 8; i++) exp_addr_q.push_back(b + 32'(4 * i));
  endtask

  // Backing memory model: grants, in-order responses after 'lat' cycles.
  always @(negedge clk) begin
    int nxt;
    pend_t p;
    logic [31:0] ea;
    nxt = ecnt + 1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.mem_gnt    = 1'b0;
    if (rst) begin
      pend_q.delete();
      tb_out = 0;
    end else begin
      if (pend_q.size() > 0 && pend_q[0].due <= nxt) begin
        p = pend_q.pop_front();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = p.data;
        tb_out--;
        rv_cnt++;
      end
      bus.mem_gnt = gnt_toggle ? ((nxt % 2) == 0) : 1'b1;
      if (bus.mem_req) req_seen++;
      if (bus.mem_req && bus.mem_gnt) begin
        tb_out++;
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant: got addr %0h required no request", bus.mem_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          check("mem_addr", bus.mem_addr, ea);
        end
        check("outstanding_le_max", tb_out <= MAX_OUT, 1);
        p.data = 32'hA000_0000 + mem_seed + {29'b0, bus.mem_addr[4:2]};
        p.due  = nxt + lat;
        pend_q.push_back(p);
      end
    end
  end

  // Response monitor: pops the expected line on every done pulse.
  logic [255:0] held_exp;
  bit           held_chk = 1'b0;
  always @(negedge clk) begin
    if (held_chk) begin
      check("data_held", bus.immu_read_data, held_exp);
      held_chk = 1'b0;
    end
    if (!rst && bus.immu_done === 1'b1) begin
      done_cnt++;
      if (exp_line_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 required no done");
      end else begin
        held_exp = exp_line_q.pop_front();
        check("line_data", bus.immu_read_data, held_exp);
        held_chk = 1'b1;
      end
    end
  end

  // Issues one request and holds it until done; returns done cycle minus acceptance cycle.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] seed, input bit full,
                        output int lat_cyc);
    int acc;
    bit seen;
    @(negedge clk);
    mem_seed = seed;
    if (full) push_addrs(addr);
    exp_line_q.push_back(line_of(seed));
    bus.immu_addr = addr;
    bus.immu_read = 1'b1;
    acc = ecnt;
    seen = 1'b0;
    lat_cyc = -1;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      bus.immu_addr = 32'hFFFF_FFE0;
      if (bus.immu_done === 1'b1) begin
        seen = 1'b1;
        lat_cyc = ecnt - acc;
      end
    end
    bus.immu_read = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done required done for addr %0h", addr);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"}, bus.immu_done, 0);
    check({tag, "_data"}, bus.immu_read_data, 0);
    check({tag, "_mem_req"}, bus.mem_req, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l, dc0, rv0, rs, d_cyc, first_req;
    bit ok;
    rst = 1'b1;
    bus.immu_read  = 1'b0;
    bus.immu_addr  = '0;
    bus.inv_line   = 1'b0;
    bus.mem_gnt    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: zero-wait memory, 0x1234 -> words from 0x1220, done at cycle 10
    do_req(32'h0000_1234, 32'h0, 1'b1, l);
    check("t1_latency", l, 10);
    check("t1_all_addrs_issued", exp_addr_q.size(), 0);

    // 2: grant toggling, response latency 3
    gnt_toggle = 1'b1;
    lat = 3;
    dc0 = done_cnt;
    do_req(32'h0000_2040, 32'h100, 1'b1, l);
    check("t2_one_done", done_cnt - dc0, 1);
    check("t2_all_addrs_issued", exp_addr_q.size(), 0);
    gnt_toggle = 1'b0;
    lat = 1;

    // 3: reset after four words, then a new fill at 0x8000
    @(negedge clk);
    mem_seed = 32'h180;
    push_addrs(32'h0000_3000);
    bus.immu_addr = 32'h0000_3000;
    bus.immu_read = 1'b1;
    rv0 = rv_cnt;
    dc0 = done_cnt;
    ok  = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (rv_cnt - rv0 >= 4) ok = 1'b1;
    end
    check("t3_four_words_seen", ok, 1);
    @(negedge clk);
    rst = 1'b1;
    bus.immu_read = 1'b0;
    exp_addr_q.delete();
    repeat (3) @(negedge clk);
    check_reset_outputs("t3_reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_no_done_aborted", done_cnt - dc0, 0);
    do_req(32'h0000_8000, 32'h200, 1'b1, l);
    check("t3_new_fill_latency", l, 10);

    // 4: request held through RESP/RECOVER; next accept 2 cycles after done
    bus.inv_line = 1'b1;
    dc0 = done_cnt;
    @(negedge clk);
    mem_seed = 32'h300;
    push_addrs(32'h0000_4000);
    push_addrs(32'h0000_4000);
    exp_line_q.push_back(line_of(32'h300));
    exp_line_q.push_back(line_of(32'h300));
    bus.immu_addr = 32'h0000_4000;
    bus.immu_read = 1'b1;
    d_cyc = -1;
    for (int k = 0; k < 100 && d_cyc < 0; k++) begin
      @(negedge clk);
      if (bus.immu_done === 1'b1) d_cyc = ecnt;
    end
    first_req = -1;
    for (int k = 0; k < 10 && first_req < 0; k++) begin
      @(negedge clk);
      if (bus.mem_req === 1'b1) first_req = ecnt;
    end
    check("t4_first_done_seen", d_cyc >= 0, 1);
    check("t4_next_req_offset", first_req - d_cyc, 3);
    bus.immu_read = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (bus.immu_done === 1'b1) ok = 1'b1;
    end
    repeat (3) @(negedge clk);
    check("t4_two_dones", done_cnt - dc0, 2);
    bus.inv_line = 1'b0;

    // 5: last-line shortcut (or full refill when the feature is absent)
    do_req(32'h0000_1234, 32'h500, 1'b1, l);
    check("t5_first_fill_latency", l, 10);
`ifdef IMMU_LAST_LINE_EN
    rs = req_seen;
    do_req(32'h0000_1234, 32'h500, 1'b0, l);
    check("t5_hit_latency", l, 1);
    check("t5_hit_no_mem_req", req_seen - rs, 0);
    @(negedge clk);
    bus.inv_line = 1'b1;
    @(negedge clk);
    bus.inv_line = 1'b0;
    do_req(32'h0000_1234, 32'h600, 1'b1, l);
    check("t5_after_inv_latency", l, 10);
`else
    rs = req_seen;
    do_req(32'h0000_1234, 32'h500, 1'b1, l);
    check("t5_repeat_full_latency", l, 10);
    check("t5_repeat_req_cycles", req_seen - rs, 8);
`endif

    repeat (5) @(negedge clk);
    check("end_lines_drained", exp_line_q.size(), 0);
    check("end_addrs_drained", exp_addr_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
